instr_mem: RTL and testbench

Instruction-side memory slave for the cv32e40p core: consumes the core's OBI instruction fetch requests (`instr_req`/`instr_addr`) and produces `instr_gnt`, `instr_rvalid` and `instr_rdata`. It sits in the top level beside the data-side `bus`, directly downstream of the core's instruction port. Grant and response latency are configurable so fetch-path stalls can be exercised. A backdoor load port lets the testbench write program images without going through the core.

---
 rtl/instr_mem.sv | 137 +++++++++++++
 tb/tb_instr_mem.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem
// Purpose  : Instruction-side memory slave for the cv32e40p fetch port (OBI).
//            It accepts fetch requests, grants them after a programmable wait,
//            and returns the addressed word after a programmable latency.
//            Responses come back in grant order. A backdoor port writes
//            program images directly into the array.
// Ports    : clk_i, rst_ni (synchronous, active-low)
//            instr_req_i, instr_addr_i  -> fetch request / byte address
//            instr_gnt_o                <- address accepted this cycle
//            instr_rvalid_o, instr_rdata_o <- one response per grant
//            load_we_i, load_addr_i, load_wdata_i -> backdoor word write
//                                          (address relative to BASE_ADDR)
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem #(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned GNT_WAIT    = 0,
   parameter int unsigned RESP_LAT    = 1,
   parameter int unsigned MAX_OUTST   = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   input  logic        load_we_i,
   input  logic [31:0] load_addr_i,
   input  logic [31:0] load_wdata_i
);

   localparam int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [2:0]  GNT_WAIT_C  = 3'(GNT_WAIT);
   localparam logic [2:0]  MAX_OUTST_C = 3'(MAX_OUTST);
   localparam logic [31:0] DEPTH_C     = 32'(DEPTH_WORDS);

   logic [31:0]         mem [DEPTH_WORDS];

   logic [2:0]          wait_cnt;
   logic [2:0]          outst;
   logic                gnt;

   logic [31:0]         fetch_word;
   logic                fetch_in_range;
   logic [31:0]         fetch_data;
   logic [31:0]         load_word;
   logic                load_in_range;

   logic [RESP_LAT-1:0] pipe_valid;
   logic [31:0]         pipe_data [RESP_LAT];

   // Word offsets from the start of the array. The subtraction wraps for
   // addresses below BASE_ADDR, so a single unsigned compare covers both
   // the low and the high out-of-range cases.
   assign fetch_word     = (instr_addr_i - BASE_ADDR) >> 2;
   assign fetch_in_range = (fetch_word < DEPTH_C);
   assign load_word      = load_addr_i >> 2;
   assign load_in_range  = (load_word < DEPTH_C);

   // Grant looks only at the registered outstanding count: a response
   // retiring this cycle does not open a slot until the next cycle.
   assign gnt = rst_ni & instr_req_i & (wait_cnt == GNT_WAIT_C) & (outst < MAX_OUTST_C);

   assign instr_gnt_o    = gnt;
   assign instr_rvalid_o = pipe_valid[RESP_LAT-1];
   assign instr_rdata_o  = pipe_data[RESP_LAT-1];

   // Out-of-range fetches return all zeros, an illegal instruction.
   always_comb begin
      fetch_data = 32'h0000_0000;
      if (fetch_in_range) begin
         fetch_data = mem[fetch_word[IDX_W-1:0]];
      end
   end

   // Memory array is never reset so program images survive a core reset.
   // A backdoor write and a grant to the same word in one cycle return the
   // old word because the read is captured on the same edge as the write.
   always_ff @(posedge clk_i) begin
      if (load_we_i && load_in_range) begin
         mem[load_word[IDX_W-1:0]] <= load_wdata_i;
      end
   end

   // Wait counter saturates at GNT_WAIT, so a request that becomes eligible
   // but is held back by the outstanding limit is granted as soon as a slot
   // frees up.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wait_cnt <= 3'd0;
      end else if (!instr_req_i || gnt) begin
         wait_cnt <= 3'd0;
      end else if (wait_cnt < GNT_WAIT_C) begin
         wait_cnt <= wait_cnt + 3'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         outst <= 3'd0;
      end else begin
         case ({gnt, pipe_valid[RESP_LAT-1]})
            2'b10:   outst <= outst + 3'd1;
            2'b01:   outst <= outst - 3'd1;
            default: outst <= outst;
         endcase
      end
   end

   // Response shift register. Data in a stage only moves when a valid word
   // moves into it, so the last stage holds its value between responses.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pipe_valid <= '0;
         for (int i = 0; i < RESP_LAT; i++) begin
            pipe_data[i] <= 32'h0000_0000;
         end
      end else begin
         pipe_valid[0] <= gnt;
         if (gnt) begin
            pipe_data[0] <= fetch_data;
         end
         for (int i = 1; i < RESP_LAT; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            if (pipe_valid[i-1]) begin
               pipe_data[i] <= pipe_data[i-1];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem
// Purpose  : Directed self-checking bench for instr_mem. Three instances:
//            A - defaults (GNT_WAIT=0, RESP_LAT=1)
//            B - GNT_WAIT=3
//            C - RESP_LAT=2, MAX_OUTST=2, non-zero BASE_ADDR
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem;

   localparam logic [31:0] C_BASE = 32'h0002_0000;

   logic        clk;
   logic        rst_n;

   logic        a_req, a_gnt, a_rvalid, a_we;
   logic [31:0] a_addr, a_rdata, a_laddr, a_wdata;
   logic        b_req, b_gnt, b_rvalid, b_we;
   logic [31:0] b_addr, b_rdata, b_laddr, b_wdata;
   logic        c_req, c_gnt, c_rvalid, c_we;
   logic [31:0] c_addr, c_rdata, c_laddr, c_wdata;

   int vectors     = 0;
   int miscompares = 0;

   instr_mem dut_a (
      .clk_i(clk), .rst_ni(rst_n),
      .instr_req_i(a_req), .instr_addr_i(a_addr), .instr_gnt_o(a_gnt),
      .instr_rvalid_o(a_rvalid), .instr_rdata_o(a_rdata),
      .load_we_i(a_we), .load_addr_i(a_laddr), .load_wdata_i(a_wdata)
   );

   instr_mem #(.GNT_WAIT(3)) dut_b (
      .clk_i(clk), .rst_ni(rst_n),
      .instr_req_i(b_req), .instr_addr_i(b_addr), .instr_gnt_o(b_gnt),
      .instr_rvalid_o(b_rvalid), .instr_rdata_o(b_rdata),
      .load_we_i(b_we), .load_addr_i(b_laddr), .load_wdata_i(b_wdata)
   );

   instr_mem #(.DEPTH_WORDS(1024), .BASE_ADDR(C_BASE), .RESP_LAT(2), .MAX_OUTST(2)) dut_c (
      .clk_i(clk), .rst_ni(rst_n),
      .instr_req_i(c_req), .instr_addr_i(c_addr), .instr_gnt_o(c_gnt),
      .instr_rvalid_o(c_rvalid), .instr_rdata_o(c_rdata),
      .load_we_i(c_we), .load_addr_i(c_laddr), .load_wdata_i(c_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here and
   // outputs are checked 3 time units later, well before the next edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      a_req = 1'b1; a_addr = 32'h0; a_we = 1'b0; a_laddr = 32'h0; a_wdata = 32'h0;
      b_req = 1'b0; b_addr = 32'h0; b_we = 1'b0; b_laddr = 32'h0; b_wdata = 32'h0;
      c_req = 1'b0; c_addr = 32'h0; c_we = 1'b0; c_laddr = 32'h0; c_wdata = 32'h0;

      // ---------------- reset state ----------------
      cyc(); cyc(); #3;
      check("rst_a_gnt",    {31'd0, a_gnt},    32'd0);
      check("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
      check("rst_a_rdata",  a_rdata,           32'd0);
      check("rst_c_rvalid", {31'd0, c_rvalid}, 32'd0);

      cyc(); rst_n = 1'b1; a_req = 1'b0;

      // ---------------- backdoor loads ----------------
      cyc();
      a_we = 1'b1; a_laddr = 32'h0;  a_wdata = 32'h0000_0513;
      b_we = 1'b1; b_laddr = 32'h8;  b_wdata = 32'h0020_0613;
      c_we = 1'b1; c_laddr = 32'h0;  c_wdata = 32'h0000_00C0;
      cyc();
      a_laddr = 32'h4;  a_wdata = 32'h0010_0593;
      c_laddr = 32'h4;  c_wdata = 32'h0000_00C1;
      b_we = 1'b0;
      cyc();
      a_laddr = 32'h14; a_wdata = 32'h1111_1111;
      c_laddr = 32'h8;  c_wdata = 32'h0000_00C2;
      cyc();
      a_laddr = 32'h4000; a_wdata = 32'hFFFF_FFFF;   // out of range: dropped
      c_we = 1'b0;
      cyc();
      a_we = 1'b0;

      // ---------------- A: back-to-back fetches ----------------
      cyc(); a_req = 1'b1; a_addr = 32'h0; #3;
      check("a_b2b_gnt0", {31'd0, a_gnt}, 32'd1);
      check("a_b2b_rv0",  {31'd0, a_rvalid}, 32'd0);
      cyc(); a_addr = 32'h4; #3;
      check("a_b2b_gnt1", {31'd0, a_gnt}, 32'd1);
      check("a_b2b_rv1",  {31'd0, a_rvalid}, 32'd1);
      check("a_b2b_rd1",  a_rdata, 32'h0000_0513);
      cyc(); a_req = 1'b0; #3;
      check("a_b2b_gnt2", {31'd0, a_gnt}, 32'd0);
      check("a_b2b_rv2",  {31'd0, a_rvalid}, 32'd1);
      check("a_b2b_rd2",  a_rdata, 32'h0010_0593);
      cyc(); #3;
      check("a_idle_rv",   {31'd0, a_rvalid}, 32'd0);
      check("a_hold_rd",   a_rdata, 32'h0010_0593);

      // ---------------- A: out-of-range fetch ----------------
      cyc(); a_req = 1'b1; a_addr = 32'h4000; #3;
      check("a_oor_gnt", {31'd0, a_gnt}, 32'd1);
      cyc(); a_req = 1'b0; #3;
      check("a_oor_rv",  {31'd0, a_rvalid}, 32'd1);
      check("a_oor_rd",  a_rdata, 32'h0000_0000);

      // ---------------- A: same-cycle load and fetch ----------------
      cyc(); a_req = 1'b1; a_addr = 32'h14;
      a_we = 1'b1; a_laddr = 32'h14; a_wdata = 32'hDEAD_BEEF; #3;
      check("a_rmw_gnt", {31'd0, a_gnt}, 32'd1);
      cyc(); a_we = 1'b0; #3;
      check("a_rmw_rv",  {31'd0, a_rvalid}, 32'd1);
      check("a_rmw_old", a_rdata, 32'h1111_1111);
      check("a_refetch_gnt", {31'd0, a_gnt}, 32'd1);
      cyc(); a_req = 1'b0; #3;
      check("a_refetch_new", a_rdata, 32'hDEAD_BEEF);

      // word 0 must not have been hit by the out-of-range load
      cyc(); a_req = 1'b1; a_addr = 32'h0;
      cyc(); a_req = 1'b0; #3;
      check("a_oorw_rv", {31'd0, a_rvalid}, 32'd1);
      check("a_oorw_rd", a_rdata, 32'h0000_0513);

      // ---------------- B: grant wait of 3 ----------------
      cyc(); b_req = 1'b1; b_addr = 32'h8; #3;
      check("b_t0_gnt", {31'd0, b_gnt}, 32'd0);
      cyc(); #3; check("b_t1_gnt", {31'd0, b_gnt}, 32'd0);
      cyc(); #3; check("b_t2_gnt", {31'd0, b_gnt}, 32'd0);
      cyc(); #3;
      check("b_t3_gnt", {31'd0, b_gnt}, 32'd1);
      check("b_t3_rv",  {31'd0, b_rvalid}, 32'd0);
      cyc(); b_req = 1'b0; #3;
      check("b_t4_gnt", {31'd0, b_gnt}, 32'd0);
      check("b_t4_rv",  {31'd0, b_rvalid}, 32'd1);
      check("b_t4_rd",  b_rdata, 32'h0020_0613);

      // abandoned request restarts the wait
      cyc(); b_req = 1'b1; #3; check("b_ab_t0", {31'd0, b_gnt}, 32'd0);
      cyc(); b_req = 1'b0; #3; check("b_ab_t1", {31'd0, b_gnt}, 32'd0);
      cyc(); b_req = 1'b1; #3; check("b_ab_t2", {31'd0, b_gnt}, 32'd0);
      cyc(); #3; check("b_ab_t3", {31'd0, b_gnt}, 32'd0);
      cyc(); #3; check("b_ab_t4", {31'd0, b_gnt}, 32'd0);
      cyc(); #3; check("b_ab_t5", {31'd0, b_gnt}, 32'd1);
      cyc(); b_req = 1'b0; #3;
      check("b_ab_rv", {31'd0, b_rvalid}, 32'd1);
      check("b_ab_rd", b_rdata, 32'h0020_0613);

      // ---------------- C: saturation with RESP_LAT=2, MAX_OUTST=2 ----------------
      cyc(); c_req = 1'b1; c_addr = C_BASE; #3;
      check("c_t0_gnt", {31'd0, c_gnt}, 32'd1);
      check("c_t0_rv",  {31'd0, c_rvalid}, 32'd0);
      cyc(); c_addr = C_BASE + 32'h4; #3;
      check("c_t1_gnt", {31'd0, c_gnt}, 32'd1);
      check("c_t1_rv",  {31'd0, c_rvalid}, 32'd0);
      cyc(); c_addr = C_BASE + 32'h8; #3;
      check("c_t2_gnt", {31'd0, c_gnt}, 32'd0);
      check("c_t2_rv",  {31'd0, c_rvalid}, 32'd1);
      check("c_t2_rd",  c_rdata, 32'h0000_00C0);
      cyc(); #3;
      check("c_t3_gnt", {31'd0, c_gnt}, 32'd1);
      check("c_t3_rv",  {31'd0, c_rvalid}, 32'd1);
      check("c_t3_rd",  c_rdata, 32'h0000_00C1);
      cyc(); c_req = 1'b0; #3;
      check("c_t4_gnt", {31'd0, c_gnt}, 32'd0);
      check("c_t4_rv",  {31'd0, c_rvalid}, 32'd0);
      check("c_t4_rd",  c_rdata, 32'h0000_00C1);
      cyc(); #3;
      check("c_t5_rv",  {31'd0, c_rvalid}, 32'd1);
      check("c_t5_rd",  c_rdata, 32'h0000_00C2);
      cyc(); #3;
      check("c_t6_rv",  {31'd0, c_rvalid}, 32'd0);

      // ---------------- C: reset discards an in-flight response ----------------
      cyc(); c_req = 1'b1; c_addr = C_BASE + 32'h4; #3;
      check("c_rst_gnt", {31'd0, c_gnt}, 32'd1);
      cyc(); c_req = 1'b0; rst_n = 1'b0; #3;
      check("c_rst_rv0", {31'd0, c_rvalid}, 32'd0);
      cyc(); rst_n = 1'b1; #3;
      check("c_rst_rv1", {31'd0, c_rvalid}, 32'd0);
      check("c_rst_rd1", c_rdata, 32'h0000_0000);
      check("a_rst_rd",  a_rdata, 32'h0000_0000);
      cyc(); #3;
      check("c_rst_rv2", {31'd0, c_rvalid}, 32'd0);

      // fetch after reset; memory contents survive
      cyc(); c_req = 1'b1; c_addr = C_BASE + 32'h8; a_req = 1'b1; a_addr = 32'h14; #3;
      check("c_post_gnt", {31'd0, c_gnt}, 32'd1);
      check("a_post_gnt", {31'd0, a_gnt}, 32'd1);
      cyc(); c_req = 1'b0; a_req = 1'b0; #3;
      check("c_post_rv0", {31'd0, c_rvalid}, 32'd0);
      check("a_post_rv",  {31'd0, a_rvalid}, 32'd1);
      check("a_post_rd",  a_rdata, 32'hDEAD_BEEF);
      cyc(); #3;
      check("c_post_rv1", {31'd0, c_rvalid}, 32'd1);
      check("c_post_rd",  c_rdata, 32'h0000_00C2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
